// File: rtl/mul_seq64.sv
// mul_seq64: multi-cycle unsigned 64x64->128 shift-add multiplier controller
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request, accepted in IDLE or DONE
//   flush   synchronous abort to IDLE (wins over start)
//   a, b    multiplicand / multiplier, captured on accept
//   busy    high while iterating
//   done    one-cycle pulse when prod_hi/prod_lo are fresh
//   prod_lo product bits [63:0], prod_hi product bits [127:64]
module adder64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'b0, cin};
endmodule

module mul_seq64 #(
   parameter int ITER = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] prod_lo,
   output logic [63:0] prod_hi
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_n;
   logic [63:0] mcand, hi, lo, sum, hi_n, lo_n;
   logic [6:0] cnt;
   logic cout, accept, last;

   adder64 u_add (
      .a(hi),
      .b(lo[0] ? mcand : 64'd0),
      .cin(1'b0),
      .sum(sum),
      .cout(cout)
   );

   // carry enters the accumulator top so the 128-bit result stays exact
   assign hi_n = {cout, sum[63:1]};
   assign lo_n = {sum[0], lo[63:1]};
   assign accept = start && state != RUN;
   assign last = state == RUN && cnt == 7'(ITER - 1);
   assign busy = state == RUN;
   assign done = state == FIN;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      if (flush) state_n = IDLE;
      else if (accept) state_n = RUN;
      else if (state == FIN) state_n = IDLE;
      else if (last) state_n = FIN;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mcand <= '0;
         hi <= '0;
         lo <= '0;
         cnt <= '0;
         prod_lo <= '0;
         prod_hi <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (accept) begin
         mcand <= a;
         hi <= '0;
         lo <= b;
         cnt <= '0;
      end else if (state == RUN) begin
         hi <= hi_n;
         lo <= lo_n;
         cnt <= cnt + 7'd1;
         if (last) begin
            prod_hi <= hi_n;
            prod_lo <= lo_n;
         end
      end
endmodule

// File: tb/tb_mul_seq64.sv
// tb_mul_seq64: scoreboard bench for mul_seq64 with directed vectors
module tb_mul_seq64;
   logic clk = 0, rst = 1, start = 0, flush = 0;
   logic [63:0] a = 0, b = 0;
   logic busy, done;
   logic [63:0] prod_lo, prod_hi;
   int cyc = 0, n_chk = 0, n_fail = 0;

   typedef struct {logic [127:0] p; int c;} exp_t;
   exp_t q[$];

   mul_seq64 dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .a(a), .b(b),
      .busy(busy), .done(done), .prod_lo(prod_lo), .prod_hi(prod_hi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = q.pop_front();
            chk("product", {prod_hi, prod_lo}, e.p);
            chk("latency", 128'(cyc), 128'(e.c));
            chk("busy_in_done", 128'(busy), 128'(0));
         end
      end
   end

   task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic [127:0] p, input bit push);
      exp_t e;
      start = 1;
      a = x;
      b = y;
      e.p = p;
      e.c = cyc + 65;
      if (push) q.push_back(e);
   endtask

   task automatic wait_done(input int poke, output int busy_n, output int chg);
      logic [127:0] p0;
      p0 = {prod_hi, prod_lo};
      busy_n = 0;
      chg = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         start = k == poke;
         if (poke >= 0) begin
            a = (k == poke) ? 64'd100 : {$urandom, $urandom};
            b = (k == poke) ? 64'd100 : {$urandom, $urandom};
         end
         if (done) return;
         busy_n += busy;
         if ({prod_hi, prod_lo} !== p0) chg++;
      end
      chk("done_timeout", 128'(0), 128'(1));
   endtask

   initial begin
      int bn, ch, dn;
      @(negedge clk);
      @(negedge clk);
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_done", 128'(done), 128'(0));
      chk("reset_prod", {prod_hi, prod_lo}, 128'(0));
      rst = 0;
      @(negedge clk);
      issue(64'd3, 64'd5, 128'd15, 1);
      wait_done(-1, bn, ch);
      chk("basic_busy_cycles", 128'(bn), 128'(64));
      @(negedge clk);
      chk("done_pulse_width", 128'(done), 128'(0));
      chk("idle_busy", 128'(busy), 128'(0));
      chk("hold_before_zero_op", {prod_hi, prod_lo}, 128'd15);
      issue(64'h1234, 64'd0, 128'd0, 1);
      wait_done(-1, bn, ch);
      chk("zero_busy_cycles", 128'(bn), 128'(64));
      chk("hold_during_run", 128'(ch), 128'(0));
      @(negedge clk);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}, 1);
      wait_done(-1, bn, ch);
      @(negedge clk);
      issue(64'h8000_0000_0000_0000, 64'd2, {64'd1, 64'd0}, 1);
      wait_done(-1, bn, ch);
      @(negedge clk);
      issue(64'd7, 64'd9, 128'd63, 1);
      wait_done(9, bn, ch);
      chk("protect_busy_cycles", 128'(bn), 128'(64));
      issue(64'd6, 64'd7, 128'd42, 1);
      wait_done(-1, bn, ch);
      chk("b2b_busy_cycles", 128'(bn), 128'(64));
      @(negedge clk);
      issue(64'd11, 64'd13, 128'd143, 0);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         start = 0;
      end
      flush = 1;
      start = 1;
      a = 64'd2;
      b = 64'd2;
      @(negedge clk);
      flush = 0;
      start = 0;
      chk("flush_busy", 128'(busy), 128'(0));
      chk("flush_done", 128'(done), 128'(0));
      chk("flush_prod", {prod_hi, prod_lo}, 128'd42);
      bn = 0;
      dn = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         bn += busy;
         dn += done;
      end
      chk("flush_no_done", 128'(dn), 128'(0));
      chk("flush_no_restart", 128'(bn), 128'(0));
      issue(64'd5, 64'd5, 128'd25, 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start = 0;
      end
      chk("pre_rst_busy", 128'(busy), 128'(1));
      #2 rst = 1;
      #1;
      chk("async_rst_busy", 128'(busy), 128'(0));
      chk("async_rst_done", 128'(done), 128'(0));
      chk("async_rst_prod", {prod_hi, prod_lo}, 128'(0));
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      issue(64'hDEAD_BEEF, 64'h10, 128'hD_EADB_EEF0, 1);
      wait_done(-1, bn, ch);
      @(negedge clk);
      chk("queue_empty", 128'(q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
